// File: rtl/code_lock_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : code_lock_ctrl
// Purpose  : Keypad lock decision engine with programmable code, relock timer,
//            entry timeout and failed-attempt lockout. Optional double-entry
//            confirmation of a new code when SAVE_CONFIRM_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
module code_lock_ctrl #(
    parameter int                      CODE_LEN     = 4,
    parameter logic [4*CODE_LEN-1:0]   DEFAULT_CODE = 16'h1234,
    parameter int                      MAX_FAIL     = 3,
    parameter int                      OPEN_CYCLES  = 500,
    parameter int                      LOCK_CYCLES  = 1000,
    parameter int                      IDLE_TIMEOUT = 2000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       Valid,
    input  logic [3:0] Code,
    output logic       OPEN,
    output logic       SAVE_LIGHT,
    output logic       LOCKOUT,
    output logic [3:0] FAIL_CNT,
    output logic [3:0] DIGIT_CNT
);

    localparam int c_bw   = 4 * CODE_LEN;
    localparam int c_tmax = (OPEN_CYCLES > LOCK_CYCLES)
                          ? ((OPEN_CYCLES > IDLE_TIMEOUT) ? OPEN_CYCLES : IDLE_TIMEOUT)
                          : ((LOCK_CYCLES > IDLE_TIMEOUT) ? LOCK_CYCLES : IDLE_TIMEOUT);
    localparam int c_tw   = $clog2(c_tmax + 1);

    localparam logic [c_tw-1:0] c_open_ld = c_tw'(OPEN_CYCLES - 1);
    localparam logic [c_tw-1:0] c_lock_ld = c_tw'(LOCK_CYCLES - 1);
    localparam logic [c_tw-1:0] c_idle_ld = c_tw'(IDLE_TIMEOUT - 1);
    localparam logic [3:0]      c_len      = 4'(CODE_LEN);
    localparam logic [3:0]      c_max_fail = 4'(MAX_FAIL);
    localparam logic [3:0]      c_key_star = 4'd10;
    localparam logic [3:0]      c_key_hash = 4'd11;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_ENTRY   = 3'd1,
        S_CHECK   = 3'd2,
        S_OPENED  = 3'd3,
        S_SAVE    = 3'd4,
        S_CONFIRM = 3'd5,
        S_LOCKOUT = 3'd6
    } state_t;

    state_t            r_state;
    logic [c_bw-1:0]   r_buf;
    logic [c_bw-1:0]   r_code;
`ifdef SAVE_CONFIRM_EN
    logic [c_bw-1:0]   r_shadow;
`endif
    logic [3:0]        r_digit_cnt;
    logic              r_ovf;
    logic [3:0]        r_fail_cnt;
    logic [c_tw-1:0]   r_timer;
    logic              r_open;
    logic              r_save_light;
    logic              r_lockout;

    logic              w_key;
    logic              w_digit;
    logic              w_star;
    logic              w_hash;
    logic              w_expired;
    logic              w_entry_ok;
    logic              w_full;
    logic [c_bw-1:0]   w_shift;

    // Codes 12-15 never count as a key press, not even for the timeout.
    assign w_key      = Valid && (Code < 4'd12);
    assign w_digit    = w_key && (Code < 4'd10);
    assign w_star     = w_key && (Code == c_key_star);
    assign w_hash     = w_key && (Code == c_key_hash);
    assign w_expired  = (r_timer == '0);
    assign w_full     = (r_digit_cnt == c_len);
    assign w_entry_ok = w_full && !r_ovf;
    assign w_shift    = (r_buf << 4) | c_bw'(Code);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state      <= S_IDLE;
            r_buf        <= '0;
            r_code       <= DEFAULT_CODE;
`ifdef SAVE_CONFIRM_EN
            r_shadow     <= '0;
`endif
            r_digit_cnt  <= '0;
            r_ovf        <= 1'b0;
            r_fail_cnt   <= '0;
            r_timer      <= '0;
            r_open       <= 1'b0;
            r_save_light <= 1'b0;
            r_lockout    <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_digit) begin
                        r_buf       <= c_bw'(Code);
                        r_digit_cnt <= 4'd1;
                        r_ovf       <= 1'b0;
                        r_timer     <= c_idle_ld;
                        r_state     <= S_ENTRY;
                    end
                end

                S_ENTRY, S_SAVE, S_CONFIRM: begin
                    if (w_digit) begin
                        r_buf   <= w_shift;
                        r_timer <= c_idle_ld;
                        if (w_full) begin
                            r_ovf <= 1'b1;
                        end else begin
                            r_digit_cnt <= r_digit_cnt + 4'd1;
                        end
                    end else if (w_hash && (r_state == S_ENTRY)) begin
                        r_timer <= c_idle_ld;
                        r_state <= S_CHECK;
                    end else if (w_hash) begin
                        r_buf       <= '0;
                        r_digit_cnt <= '0;
                        r_ovf       <= 1'b0;
                        r_timer     <= c_idle_ld;
`ifdef SAVE_CONFIRM_EN
                        if ((r_state == S_SAVE) && w_entry_ok) begin
                            r_shadow <= r_buf;
                            r_state  <= S_CONFIRM;
                        end else begin
                            if (w_entry_ok && (r_buf == r_shadow)) begin
                                r_code <= r_buf;
                            end
                            r_save_light <= 1'b0;
                            r_state      <= S_IDLE;
                        end
`else
                        if (w_entry_ok) begin
                            r_code <= r_buf;
                        end
                        r_save_light <= 1'b0;
                        r_state      <= S_IDLE;
`endif
                    end else if (w_star || w_expired) begin
                        r_buf        <= '0;
                        r_digit_cnt  <= '0;
                        r_ovf        <= 1'b0;
                        r_save_light <= 1'b0;
                        r_timer      <= c_idle_ld;
                        r_state      <= S_IDLE;
                    end else begin
                        r_timer <= r_timer - 1'b1;
                    end
                end

                S_CHECK: begin
                    r_buf       <= '0;
                    r_digit_cnt <= '0;
                    r_ovf       <= 1'b0;
                    if (w_entry_ok && (r_buf == r_code)) begin
                        r_fail_cnt <= '0;
                        r_open     <= 1'b1;
                        r_timer    <= c_open_ld;
                        r_state    <= S_OPENED;
                    end else if ((r_fail_cnt + 4'd1) == c_max_fail) begin
                        r_fail_cnt <= r_fail_cnt + 4'd1;
                        r_lockout  <= 1'b1;
                        r_timer    <= c_lock_ld;
                        r_state    <= S_LOCKOUT;
                    end else begin
                        r_fail_cnt <= r_fail_cnt + 4'd1;
                        r_state    <= S_IDLE;
                    end
                end

                S_OPENED: begin
                    // A '*' landing on the relock cycle still wins.
                    if (w_star) begin
                        r_open       <= 1'b0;
                        r_save_light <= 1'b1;
                        r_buf        <= '0;
                        r_digit_cnt  <= '0;
                        r_ovf        <= 1'b0;
                        r_timer      <= c_idle_ld;
                        r_state      <= S_SAVE;
                    end else if (w_hash || w_expired) begin
                        r_open  <= 1'b0;
                        r_state <= S_IDLE;
                    end else begin
                        r_timer <= r_timer - 1'b1;
                    end
                end

                S_LOCKOUT: begin
                    if (w_expired) begin
                        r_lockout  <= 1'b0;
                        r_fail_cnt <= '0;
                        r_state    <= S_IDLE;
                    end else begin
                        r_timer <= r_timer - 1'b1;
                    end
                end

                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign OPEN       = r_open;
    assign SAVE_LIGHT = r_save_light;
    assign LOCKOUT    = r_lockout;
    assign FAIL_CNT   = r_fail_cnt;
    assign DIGIT_CNT  = r_digit_cnt;

endmodule
`default_nettype wire

// File: tb/tb_code_lock_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_code_lock_ctrl
// Purpose  : Self-checking bench for code_lock_ctrl: vector table, directed
//            corner sequences and random keys against a queue-based model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_code_lock_ctrl;

    localparam int c_open_t = 8;
    localparam int c_lock_t = 16;
    localparam int c_idle_t = 32;
    localparam int c_maxf   = 3;
`ifdef SAVE_CONFIRM_EN
    localparam bit c_confirm = 1'b1;
`else
    localparam bit c_confirm = 1'b0;
`endif

    logic       clock = 1'b0;
    logic       rst_n = 1'b0;
    logic       valid = 1'b0;
    logic [3:0] code  = 4'd0;
    logic       open_o, save_o, lock_o;
    logic [3:0] fail_o, dcnt_o;

    int checks = 0;
    int errors = 0;

    code_lock_ctrl #(
        .CODE_LEN    (4),
        .DEFAULT_CODE(16'h1234),
        .MAX_FAIL    (c_maxf),
        .OPEN_CYCLES (c_open_t),
        .LOCK_CYCLES (c_lock_t),
        .IDLE_TIMEOUT(c_idle_t)
    ) dut (
        .clock     (clock),
        .reset     (rst_n),
        .Valid     (valid),
        .Code      (code),
        .OPEN      (open_o),
        .SAVE_LIGHT(save_o),
        .LOCKOUT   (lock_o),
        .FAIL_CNT  (fail_o),
        .DIGIT_CNT (dcnt_o)
    );

    always #5 clock = ~clock;

    // ---------------- reference model (mode + digit queue) ----------------
    // mode: 0 idle, 1 entry, 2 check, 3 open, 4 save, 5 confirm, 6 lockout
    int m_mode, m_code, m_shadow, m_fail, m_since;
    int m_q[$];
    bit m_over;

    function automatic int q_val();
        int v = 0;
        foreach (m_q[i]) v = v * 16 + m_q[i];
        return v;
    endfunction

    function automatic bit q_ok();
        return (m_q.size() == 4) && !m_over;
    endfunction

    task automatic m_clear();
        m_q.delete();
        m_over = 1'b0;
    endtask

    task automatic m_reset();
        m_clear();
        m_mode = 0; m_code = 'h1234; m_shadow = 0; m_fail = 0; m_since = 0;
    endtask

    task automatic m_push(int c);
        if (m_q.size() == 4) begin
            void'(m_q.pop_front());
            m_over = 1'b1;
        end
        m_q.push_back(c);
    endtask

    task automatic m_step(bit v, int c);
        bit key, dig, star, hash, ok;
        key  = v && (c < 12);
        dig  = key && (c < 10);
        star = key && (c == 10);
        hash = key && (c == 11);
        ok   = q_ok();
        case (m_mode)
            0: if (dig) begin m_clear(); m_push(c); m_mode = 1; m_since = 0; end
            1, 4, 5: begin
                if (dig) begin
                    m_push(c); m_since = 0;
                end else if (hash) begin
                    m_since = 0;
                    if (m_mode == 1) m_mode = 2;
                    else if (m_mode == 4 && c_confirm && ok) begin
                        m_shadow = q_val(); m_clear(); m_mode = 5;
                    end else begin
                        if (ok && (m_mode == 4 || q_val() == m_shadow)) m_code = q_val();
                        m_clear(); m_mode = 0;
                    end
                end else if (star || m_since == c_idle_t - 1) begin
                    m_clear(); m_mode = 0; m_since = 0;
                end else m_since++;
            end
            2: begin
                if (ok && q_val() == m_code) begin m_fail = 0; m_mode = 3; end
                else begin m_fail++; m_mode = (m_fail == c_maxf) ? 6 : 0; end
                m_clear(); m_since = 0;
            end
            3: begin
                if (star) begin m_clear(); m_mode = 4; m_since = 0; end
                else if (hash || m_since == c_open_t - 1) m_mode = 0;
                else m_since++;
            end
            6: begin
                if (m_since == c_lock_t - 1) begin m_fail = 0; m_mode = 0; end
                else m_since++;
            end
            default: ;
        endcase
    endtask

    // ---------------- checking helpers ----------------
    task automatic chk(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic chk_model();
        chk("model_open", int'(open_o), int'(m_mode == 3));
        chk("model_save_light", int'(save_o), int'(m_mode == 4 || m_mode == 5));
        chk("model_lockout", int'(lock_o), int'(m_mode == 6));
        chk("model_fail_cnt", int'(fail_o), m_fail);
        chk("model_digit_cnt", int'(dcnt_o), m_q.size());
    endtask

    task automatic step(bit v, int c);
        @(negedge clock);
        valid = v;
        code  = 4'(c);
        @(posedge clock);
        #1;
        m_step(v, c);
        chk_model();
    endtask

    task automatic press(int c);
        step(1'b1, c);
    endtask

    task automatic idle(int n);
        for (int i = 0; i < n; i++) step(1'b0, 0);
    endtask

    task automatic enter4(int a, int b, int c, int d);
        press(a); press(b); press(c); press(d);
    endtask

    task automatic do_reset();
        @(negedge clock);
        valid = 1'b0;
        rst_n = 1'b0;
        #1;
        m_reset();
        chk("rst_open", int'(open_o), 0);
        chk("rst_save_light", int'(save_o), 0);
        chk("rst_lockout", int'(lock_o), 0);
        chk("rst_fail_cnt", int'(fail_o), 0);
        chk("rst_digit_cnt", int'(dcnt_o), 0);
        @(negedge clock);
        rst_n = 1'b1;
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        bit v; int c;
        bit open; bit save; bit lock; int fail; int dcnt;
    } vec_t;
    vec_t tbl[$];

    task automatic add(bit v, int c, bit op, bit sv, bit lk, int fl, int dc);
        vec_t e;
        e.v = v; e.c = c; e.open = op; e.save = sv; e.lock = lk; e.fail = fl; e.dcnt = dc;
        tbl.push_back(e);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int digits[4];
        int r, n, w;

        // Open with default code, auto relock after OPEN_CYCLES.
        add(1, 1, 0, 0, 0, 0, 1); add(1, 2, 0, 0, 0, 0, 2);
        add(1, 3, 0, 0, 0, 0, 3); add(1, 4, 0, 0, 0, 0, 4);
        add(1, 11, 0, 0, 0, 0, 4);
        for (int i = 0; i < c_open_t; i++) add(0, 0, 1, 0, 0, 0, 0);
        add(0, 0, 0, 0, 0, 0, 0);
        // Three failures into lockout, keys ignored, then release.
        for (int k = 1; k <= 3; k++) begin
            add(1, 1, 0, 0, 0, k - 1, 1); add(1, 2, 0, 0, 0, k - 1, 2);
            add(1, 3, 0, 0, 0, k - 1, 3); add(1, 5, 0, 0, 0, k - 1, 4);
            add(1, 11, 0, 0, 0, k - 1, 4);
            add(0, 0, 0, 0, (k == 3), k, 0);
        end
        add(1, 1, 0, 0, 1, 3, 0); add(1, 2, 0, 0, 1, 3, 0);
        add(1, 3, 0, 0, 1, 3, 0); add(1, 4, 0, 0, 1, 3, 0);
        add(1, 11, 0, 0, 1, 3, 0);
        for (int i = 0; i < c_lock_t - 6; i++) add(0, 0, 0, 0, 1, 3, 0);
        add(0, 0, 0, 0, 0, 0, 0);
        add(1, 1, 0, 0, 0, 0, 1);
        add(1, 10, 0, 0, 0, 0, 0);

        do_reset();
        foreach (tbl[i]) begin
            step(tbl[i].v, tbl[i].c);
            chk("tbl_open", int'(open_o), int'(tbl[i].open));
            chk("tbl_save_light", int'(save_o), int'(tbl[i].save));
            chk("tbl_lockout", int'(lock_o), int'(tbl[i].lock));
            chk("tbl_fail_cnt", int'(fail_o), tbl[i].fail);
            chk("tbl_digit_cnt", int'(dcnt_o), tbl[i].dcnt);
        end

        // Save a new code.
        enter4(1, 2, 3, 4); press(11); idle(1);
        chk("save_open", int'(open_o), 1);
        press(10);
        chk("save_light_on", int'(save_o), 1);
        chk("save_open_off", int'(open_o), 0);
        enter4(9, 8, 7, 6); press(11);
        chk("save_light_off", int'(save_o), 0);
        enter4(1, 2, 3, 4); press(11); idle(1);
        chk("old_code_fail", int'(fail_o), 1);
        chk("old_code_closed", int'(open_o), 0);
        enter4(9, 8, 7, 6); press(11); idle(1);
        chk("new_code_open", int'(open_o), 1);
        chk("new_code_fail0", int'(fail_o), 0);
        press(11);
        chk("hash_relock", int'(open_o), 0);

        // Length errors.
        do_reset();
        press(1); press(2); press(3); press(11); idle(1);
        chk("short_fail", int'(fail_o), 1);
        press(5); enter4(1, 2, 3, 4);
        chk("ovf_digit_sat", int'(dcnt_o), 4);
        press(11); idle(1);
        chk("ovf_fail", int'(fail_o), 2);
        chk("ovf_closed", int'(open_o), 0);
        press(1); press(2); press(10);
        chk("star_clear", int'(dcnt_o), 0);
        enter4(1, 2, 3, 4); press(11); idle(1);
        chk("after_clear_open", int'(open_o), 1);
        press(11);

        // Entry timeout boundary.
        do_reset();
        press(1); press(2);
        idle(c_idle_t - 1);
        chk("timeout_not_yet", int'(dcnt_o), 2);
        idle(1);
        chk("timeout_cleared", int'(dcnt_o), 0);
        press(3); press(4); press(11); idle(1);
        chk("timeout_then_fail", int'(fail_o), 1);
        chk("timeout_closed", int'(open_o), 0);

        // Reset in the middle of SAVE.
        do_reset();
        enter4(1, 2, 3, 4); press(11); idle(1);
        press(10); press(9); press(8);
        chk("midsave_light", int'(save_o), 1);
        chk("midsave_dcnt", int'(dcnt_o), 2);
        do_reset();
        enter4(1, 2, 3, 4); press(11); idle(1);
        chk("post_reset_default_open", int'(open_o), 1);
        press(11);

`ifdef SAVE_CONFIRM_EN
        enter4(1, 2, 3, 4); press(11); idle(1);
        press(10);
        enter4(9, 8, 7, 6); press(11);
        chk("confirm_light_held", int'(save_o), 1);
        enter4(9, 8, 7, 5); press(11);
        chk("confirm_abort_light", int'(save_o), 0);
        enter4(9, 8, 7, 6); press(11); idle(1);
        chk("confirm_mismatch_kept", int'(fail_o), 1);
        enter4(1, 2, 3, 4); press(11); idle(1);
        chk("confirm_old_open", int'(open_o), 1);
        press(10);
        enter4(9, 8, 7, 6); press(11);
        enter4(9, 8, 7, 6); press(11);
        chk("confirm_store_light", int'(save_o), 0);
        enter4(9, 8, 7, 6); press(11); idle(1);
        chk("confirm_new_open", int'(open_o), 1);
        press(11);
`endif

        // Random keys against the model.
        do_reset();
        for (int a = 0; a < 300; a++) begin
            r = $urandom_range(0, 9);
            if (r <= 3) begin
                for (int i = 0; i < 4; i++) digits[i] = (m_code >> (4 * (3 - i))) & 15;
                for (int i = 0; i < 4; i++) begin
                    idle($urandom_range(0, 2));
                    press(digits[i]);
                end
                press(11);
            end else if (r == 4) begin
                n = $urandom_range(1, 6);
                for (int i = 0; i < n; i++) begin
                    idle($urandom_range(0, 2));
                    press($urandom_range(0, 9));
                end
                press(11);
            end else if (r == 5) begin
                press(10);
            end else if (r == 6) begin
                idle($urandom_range(0, 40));
            end else if (r == 7) begin
                press($urandom_range(12, 15));
            end else if (r == 8) begin
                press($urandom_range(0, 15));
            end else begin
                w = $urandom_range(0, 19);
                if (w == 0) do_reset();
                else press(11);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
